// File: rtl/adder_share_arbiter_pkg.sv
// Package adder_share_pkg: shared widths, FSM encoding and result-check helper
// for the shared 4-bit adder arbiter.
//   OPW      operand width fed to the adder (a and b)
//   SUMW     width of the adder output bus
//   state_t  FSM states IDLE -> CALC -> RESP
//   sum_fault returns 1 when the adder drives any bit above the 5-bit sum
package adder_share_pkg;

    localparam int OPW  = 4;
    localparam int SUMW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    // A healthy 4+4 bit adder can only produce a 5-bit result; anything set
    // above bit 4 means the adder output is corrupted.
    function automatic logic sum_fault(input logic [SUMW-1:0] sum);
        return |sum[SUMW-1:OPW+1];
    endfunction

endpackage

// File: rtl/adder_share_arbiter_if.sv
// Requester/consumer bus of the shared adder arbiter.
//   req_valid/req_ready  per-requester operand handshake (ready one-hot or zero)
//   req_a/req_b          packed operands, requester i at [4i+3:4i]
//   rsp_valid/rsp_ready  result handshake
//   rsp_id/rsp_sum       owning requester index and captured adder result
//   sum_err              adder fault flag captured with the result
// master = requester side, slave = arbiter side.
interface adder_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    import adder_share_pkg::*;

    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [OPW*NUM_REQ-1:0] req_a;
    logic [OPW*NUM_REQ-1:0] req_b;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic [SUMW-1:0]        rsp_sum;
    logic                   sum_err;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, sum_err
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, sum_err
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant search.
//   req      request vector
//   ptr      highest-priority index for this search
//   gnt      one-hot grant (zero when no request)
//   gnt_idx  index of the granted request
//   any      at least one request is present
// The search order is ptr, ptr+1, ... wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx,
    output logic               any
);

    logic [ID_W-1:0] cand_s;

    // Walk the candidates from lowest to highest priority so the last hit
    // (closest to ptr) is the one that sticks.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        cand_s  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand_s = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (req[cand_s]) begin
                gnt_idx = cand_s;
                any     = 1'b1;
            end else begin
                any     = any;
            end
        end
        if (any) begin
            gnt[gnt_idx] = 1'b1;
        end else begin
            gnt = '0;
        end
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one 4-bit adder among NUM_REQ requesters.
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   bus (slave)   requester / result-consumer handshakes
//   add_a, add_b  registered operands to the adder (ui_in[7:4], ui_in[3:0])
//   add_sum       adder output (uo_out), sampled one cycle after accept
//   busy          high whenever a transaction is in flight
// One transaction at a time: IDLE (grant) -> CALC (capture) -> RESP (hold).
module adder_share_arbiter
    import adder_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    adder_share_arbiter_if.slave bus,
    output logic [OPW-1:0]       add_a,
    output logic [OPW-1:0]       add_b,
    input  logic [SUMW-1:0]      add_sum,
    output logic                 busy
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_CALC = CALC;
    localparam logic [1:0] ST_RESP = RESP;

    logic [1:0]         state_r;
    logic [ID_W-1:0]    ptr_r;
    logic [ID_W-1:0]    ptr_nxt_s;
    logic [NUM_REQ-1:0] gnt_s;
    logic [ID_W-1:0]    gnt_idx_s;
    logic               any_s;
    logic [OPW-1:0]     op_a_s;
    logic [OPW-1:0]     op_b_s;
    logic [OPW-1:0]     add_a_r;
    logic [OPW-1:0]     add_b_r;
    logic [ID_W-1:0]    rsp_id_r;
    logic [SUMW-1:0]    rsp_sum_r;
    logic               sum_err_r;
    logic               rsp_valid_r;
    logic               busy_r;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req     (bus.req_valid),
        .ptr     (ptr_r),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s),
        .any     (any_s)
    );

    assign op_a_s = bus.req_a[int'(gnt_idx_s)*OPW +: OPW];
    assign op_b_s = bus.req_b[int'(gnt_idx_s)*OPW +: OPW];

    // Grant is offered only while idle; reset masks it so every output is 0.
    assign bus.req_ready = (state_r == ST_IDLE && !rst) ? gnt_s : '0;

    assign add_a         = add_a_r;
    assign add_b         = add_b_r;
    assign bus.rsp_id    = rsp_id_r;
    assign bus.rsp_sum   = rsp_sum_r;
    assign bus.sum_err   = sum_err_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign busy          = busy_r;

    // Next round-robin pointer: the requester after the current winner.
    always_comb begin
        ptr_nxt_s = '0;
        if (gnt_idx_s == ID_W'(NUM_REQ - 1)) begin
            ptr_nxt_s = '0;
        end else begin
            ptr_nxt_s = gnt_idx_s + ID_W'(1);
        end
    end

    // Transaction FSM with operand, result and pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            ptr_r       <= '0;
            add_a_r     <= '0;
            add_b_r     <= '0;
            rsp_id_r    <= '0;
            rsp_sum_r   <= '0;
            sum_err_r   <= 1'b0;
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_s) begin
                        add_a_r  <= op_a_s;
                        add_b_r  <= op_b_s;
                        rsp_id_r <= gnt_idx_s;
                        ptr_r    <= ptr_nxt_s;
                        busy_r   <= 1'b1;
                        state_r  <= ST_CALC;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    // Operands have been stable on the adder for a full cycle.
                    rsp_sum_r   <= add_sum;
                    sum_err_r   <= sum_fault(add_sum);
                    rsp_valid_r <= 1'b1;
                    state_r     <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r     <= ST_RESP;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter with a behavioural 4-bit adder
// (optionally corrupting the upper sum bits) and a round-robin reference model.
module tb_adder_share_arbiter;
    import adder_share_pkg::*;

    localparam int NR = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [OPW-1:0]  add_a;
    logic [OPW-1:0]  add_b;
    logic [SUMW-1:0] add_sum;
    logic            busy;
    logic [2:0]      fault_bits;

    adder_share_arbiter_if #(.NUM_REQ(NR), .ID_W(IW)) bus();

    adder_share_arbiter #(.NUM_REQ(NR), .ID_W(IW)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .add_a   (add_a),
        .add_b   (add_b),
        .add_sum (add_sum),
        .busy    (busy)
    );

    // Adder stand-in: 5-bit sum, upper bits forced by fault_bits.
    assign add_sum = {fault_bits, {1'b0, add_a} + {1'b0, add_b}};

    always #5 clk = ~clk;

    int         vectors = 0;
    int         miscompares = 0;
    int         ptr_m;
    logic [3:0] a_m [NR];
    logic [3:0] b_m [NR];
    time        t_prev;
    time        t_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_ops();
        for (int i = 0; i < NR; i++) begin
            bus.req_a[4*i +: 4] = a_m[i];
            bus.req_b[4*i +: 4] = b_m[i];
        end
    endtask

    // Reference grant: first valid requester at or after ptr_m, wrapping.
    function automatic int pick(input logic [NR-1:0] m);
        for (int k = 0; k < NR; k++) begin
            if (m[(ptr_m + k) % NR]) return (ptr_m + k) % NR;
        end
        return -1;
    endfunction

    // One full transaction, entered just after an edge with the DUT idle.
    task automatic txn(input logic [NR-1:0] mask, input int hold, output time acc_t);
        int         g;
        logic [7:0] es;
        bus.req_valid = mask;
        drive_ops();
        #1;
        g  = pick(mask);
        chk("req_ready_idle", 32'(bus.req_ready), 32'(1 << g));
        chk("busy_idle", 32'(busy), 32'd0);
        @(posedge clk);
        acc_t = $time;
        #1;
        ptr_m = (g + 1) % NR;
        es    = {fault_bits, 5'(a_m[g]) + 5'(b_m[g])};
        chk("req_ready_calc", 32'(bus.req_ready), 32'd0);
        chk("rsp_valid_calc", 32'(bus.rsp_valid), 32'd0);
        chk("busy_calc", 32'(busy), 32'd1);
        chk("add_a", 32'(add_a), 32'(a_m[g]));
        chk("add_b", 32'(add_b), 32'(b_m[g]));
        @(posedge clk);
        #1;
        chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("rsp_id", 32'(bus.rsp_id), 32'(g));
        chk("rsp_sum", 32'(bus.rsp_sum), 32'(es));
        chk("sum_err", 32'(bus.sum_err), 32'(|fault_bits));
        for (int h = 0; h < hold; h++) begin
            bus.rsp_ready = 1'b0;
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
            chk("hold_sum", 32'(bus.rsp_sum), 32'(es));
            chk("hold_id", 32'(bus.rsp_id), 32'(g));
            chk("hold_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        chk("rsp_valid_drop", 32'(bus.rsp_valid), 32'd0);
        chk("busy_drop", 32'(busy), 32'd0);
        chk("add_a_kept", 32'(add_a), 32'(a_m[g]));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        fault_bits    = 3'b000;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < NR; i++) begin
            a_m[i] = 4'd0;
            b_m[i] = 4'd0;
        end
        ptr_m = 0;
        #1;
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_add_a", 32'(add_a), 32'd0);
        chk("rst_rsp_sum", 32'(bus.rsp_sum), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic sums: 3+5 on req0, F+F on req1.
        a_m[0] = 4'd3;  b_m[0] = 4'd5;
        txn(4'b0001, 0, t_acc);
        a_m[1] = 4'hF;  b_m[1] = 4'hF;
        txn(4'b0010, 0, t_acc);

        // Bring ptr to 0, then all requesting: order 0,1,2,3,0 every 3 cycles.
        txn(4'b1000, 0, t_acc);
        for (int i = 0; i < NR; i++) begin
            a_m[i] = 4'($urandom_range(0, 15));
            b_m[i] = 4'($urandom_range(0, 15));
        end
        txn(4'b1111, 0, t_prev);
        for (int n = 0; n < 4; n++) begin
            txn(4'b1111, 0, t_acc);
            chk("throughput", 32'(t_acc - t_prev), 32'd30);
            t_prev = t_acc;
        end

        // Consumer stalls for 5 cycles.
        txn(4'b0001, 5, t_acc);

        // Requests withdrawn while idle: nothing happens.
        bus.req_valid = '0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("idle_ready", 32'(bus.req_ready), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
        end

        // ptr=3 with only req2 valid wraps around to 2, ptr stays 3.
        txn(4'b0100, 0, t_acc);
        txn(4'b0100, 0, t_acc);
        txn(4'b1111, 0, t_acc);

        // Corrupted adder output raises sum_err.
        fault_bits = 3'b101;
        txn(4'b0010, 1, t_acc);
        fault_bits = 3'b000;

        // Random traffic.
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < NR; i++) begin
                a_m[i] = 4'($urandom_range(0, 15));
                b_m[i] = 4'($urandom_range(0, 15));
            end
            fault_bits = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            txn(4'($urandom_range(1, 15)), $urandom_range(0, 2), t_acc);
        end
        fault_bits = 3'b000;

        // Reset in the middle of CALC drops the transaction and rewinds ptr.
        txn(4'b0100, 0, t_acc);
        a_m[0] = 4'h9;  b_m[0] = 4'h6;
        drive_ops();
        bus.req_valid = 4'b0001;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(bus.req_ready), 32'd0);
        chk("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_add_a", 32'(add_a), 32'd0);
        chk("mid_rst_add_b", 32'(add_b), 32'd0);
        chk("mid_rst_sum", 32'(bus.rsp_sum), 32'd0);
        chk("mid_rst_id", 32'(bus.rsp_id), 32'd0);
        #2;
        rst           = 1'b0;
        bus.req_valid = '0;
        ptr_m         = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("post_rst_valid", 32'(bus.rsp_valid), 32'd0);
            chk("post_rst_busy", 32'(busy), 32'd0);
        end
        txn(4'b1111, 0, t_acc);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
